// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder for the CPU load/store port, with configurable wait states.
// Define DMEM_BYTE_LANES_EN to honour req_be on stores; otherwise every store writes the full word.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("data_mem_responder: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_q [0:(1 << DEPTH_LOG2) - 1];

  logic                  accept;
  logic                  access;
  logic                  a_we;
  logic [31:0]           a_addr;
  logic [31:0]           a_wdata;
  logic [3:0]            a_be;
  logic                  a_err;
  logic [DEPTH_LOG2-1:0] a_idx;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept = req_ready && req_valid;
  // With zero wait states the access happens on the accept edge, so it must use the live inputs.
  assign access = rst_n && (((WAIT_STATES == 0) && accept) ||
                            ((state_q == S_WAIT) && (cnt_q == 4'd0)));

  assign a_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign a_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign a_err   = (a_addr[1:0] != 2'b00) || (a_addr[31:DEPTH_LOG2+2] != '0);
  assign a_idx   = a_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_BYTE_LANES_EN
  logic [3:0] be_q;
  assign a_be = (state_q == S_IDLE) ? req_be : be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_q <= 4'b0000;
    end else if (accept) begin
      be_q <= req_be;
    end
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign a_be      = 4'b1111;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rsp_err_q   <= a_err;
        rsp_rdata_q <= (a_err || a_we) ? 32'd0 : mem_q[a_idx];
      end
    end
  end

  // Storage has no reset; a store is only committed on an error-free access edge.
  always_ff @(posedge clk) begin
    if (access && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) begin
          mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait states, one with none.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;

  int checks;
  int errors;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_we    (req_we0),
    .req_addr  (req_addr0),
    .req_wdata (req_wdata0),
    .req_be    (req_be0),
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the 2-wait-state instance; entered and left at #1 after an edge in IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    step();
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    req_addr  = 32'h0000_0FFC;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_w0: ready=%b valid=%b, want 1 0", req_ready0, rsp_valid0);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store_0x10: lat=%0d rdata=%h err=%b, want 2 0 0", lat, rd, er);
    end
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL load_0x10: lat=%0d rdata=%h err=%b, want 2 deadbeef 0", lat, rd, er);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_rsp: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1;
    req_we0    = 1'b1;
    req_be0    = 4'hF;
    req_addr0  = 32'h4;
    req_wdata0 = 32'hCAFE_F00D;
    step();
    req_addr0  = 32'h8;
    req_wdata0 = 32'h0000_0002;
    step();
    step();
    req_we0    = 1'b0;
    req_addr0  = 32'h4;
    step();
    for (int i = 0; i < 4; i++) begin
      req_addr0 = (i % 2 == 0) ? 32'h4 : 32'h8;
      exp_rd    = (i % 2 == 0) ? 32'hCAFE_F00D : 32'h0000_0002;
      step();
      checks++;
      if (rsp_valid0 !== 1'b1 || req_ready0 !== 1'b0 || rsp_rdata0 !== exp_rd) begin
        errors++;
        $display("FAIL b2b_resp_%0d: valid=%b ready=%b rdata=%h, want 1 0 %h",
                 i, rsp_valid0, req_ready0, rsp_rdata0, exp_rd);
      end
      step();
      checks++;
      if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle_%0d: valid=%b ready=%b, want 0 1", i, rsp_valid0, req_ready0);
      end
    end
    req_valid0 = 1'b0;
    step();
  endtask

  task automatic test_stall();
    int n;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b rdata=%h ready=%b, want 1 deadbeef 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
      errors++;
      $display("FAIL err_misaligned_load: err=%b rdata=%h lat=%0d, want 1 0 2", er, rd, lat);
    end
    txn(1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL err_range_load: err=%b rdata=%h, want 1 0", er, rd);
    end
    txn(1'b1, 32'h12, 32'h1111_1111, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_misaligned_store: err=%b, want 1", er);
    end
    txn(1'b1, 32'h1010, 32'h2222_2222, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_range_store: err=%b, want 1", er);
    end
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL err_mem_unchanged: rdata=%h err=%b, want deadbeef 0", rd, er);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        er;
    int          lat;
    txn(1'b1, 32'h30, 32'h1122_3344, 4'b1111, rd, er, lat);
    txn(1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
`ifdef DMEM_BYTE_LANES_EN
    exp_rd = 32'h11BB_33DD;
`else
    exp_rd = 32'hAABB_CCDD;
`endif
    txn(1'b0, 32'h30, 32'h0, 4'b0000, rd, er, lat);
    checks++;
    if (rd !== exp_rd || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_lanes: rdata=%h err=%b, want %h 0", rd, er, exp_rd);
    end
`ifdef DMEM_BYTE_LANES_EN
    txn(1'b1, 32'h30, 32'h0000_0000, 4'b0000, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_resp: lat=%0d err=%b, want 2 0", lat, er);
    end
    txn(1'b0, 32'h30, 32'h0, 4'b1111, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL be_zero_unchanged: rdata=%h, want 11bb33dd", rd);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(1'b1, 32'h20, 32'h0123_4567, 4'hF, rd, er, lat);
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h5A5A_5A5A;
    req_be    = 4'hF;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait_outputs: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (rd !== 32'h0123_4567 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_store: rdata=%h err=%b, want 01234567 0", rd, er);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'hF;
    rsp_ready  = 1'b0;
    req_valid0 = 1'b0;
    req_we0    = 1'b0;
    req_addr0  = 32'd0;
    req_wdata0 = 32'd0;
    req_be0    = 4'hF;
    rsp_ready0 = 1'b0;

    test_reset();
    test_store_load();
    test_back_to_back();
    test_stall();
    test_errors();
    test_byte_lanes();
    test_reset_in_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
